// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the eight-digit multiplexed seven-segment scanner.
package sevenseg_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam int         DIGIT_W    = $clog2(NUM_DIGITS);
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [7:0] AN_OFF     = 8'hFF;

  typedef enum logic {
    BLANK,
    SHOW
  } state_e;

  // Index of the most significant non-zero nibble; 0 when the whole word is zero.
  function automatic logic [DIGIT_W-1:0] highest_nz(input logic [31:0] v);
    logic [DIGIT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i*4 +: 4] != 4'h0) idx = DIGIT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex-to-glyph table; segments CA..CG on bits 0..6, active-low.
module seg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (nibble_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Eight-digit display scanner with blanking gaps and a per-frame input buffer.
// Define SEVENSEG_LZ_BLANK_EN to darken leading-zero digits (digit 0 always lit).
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  digit_en,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int MAXC = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  state_e             state_q, state_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [31:0]        value_buf_q, value_buf_d;
  logic [7:0]         dp_buf_q, dp_buf_d;
  logic [7:0]         en_buf_q, en_buf_d;
  logic [7:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               fd_q, fd_d;
  logic [3:0]         nibble;
  logic [6:0]         glyph;
  logic               lz_dark;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= BLANK;
      digit_q     <= '0;
      cnt_q       <= '0;
      value_buf_q <= '0;
      dp_buf_q    <= '0;
      en_buf_q    <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_q     <= digit_d;
      cnt_q       <= cnt_d;
      value_buf_q <= value_buf_d;
      dp_buf_q    <= dp_buf_d;
      en_buf_q    <= en_buf_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      fd_q        <= fd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    digit_d     = digit_q;
    cnt_d       = cnt_q + CW'(1);
    value_buf_d = value_buf_q;
    dp_buf_d    = dp_buf_q;
    en_buf_d    = en_buf_q;
    case (state_q)
      BLANK: begin
        if (BLANK_CYCLES == 0 || cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == CW'(SCAN_DIV - 1)) begin
          digit_d = digit_q + DIGIT_W'(1);
          cnt_d   = '0;
          if (BLANK_CYCLES != 0) state_d = BLANK;
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
    // Latch on the edge that starts digit 0, so the first digit already sees the new frame.
    if (state_d == SHOW && digit_d == '0 && (state_q != SHOW || digit_q != '0)) begin
      value_buf_d = value;
      dp_buf_d    = dp_mask;
      en_buf_d    = digit_en;
    end
  end

  assign nibble = value_buf_d[digit_d*4 +: 4];

  seg_decode u_seg_decode (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

`ifdef SEVENSEG_LZ_BLANK_EN
  assign lz_dark = (digit_d > highest_nz(value_buf_d));
`else
  assign lz_dark = 1'b0;
`endif

  // Outputs are decoded from next-state values so they move on the same edge as the scan.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    fd_d  = (state_d == SHOW) && (digit_d == DIGIT_W'(NUM_DIGITS - 1)) &&
            (cnt_d == CW'(SCAN_DIV - 1));
    if (state_d == SHOW && en_buf_d[digit_d]) begin
      dp_d = ~dp_buf_d[digit_d];
      if (!lz_dark) begin
        an_d  = ~(8'(1) << digit_d);
        seg_d = glyph;
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench: two scanners (with and without blank phase) against a frame-arithmetic model.
module tb_sevenseg_scan;

  localparam int S  = 4;
  localparam int BA = 2;
  localparam int BB = 0;
`ifdef SEVENSEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] value;
  logic [7:0]  dpMask, digitEn;
  logic [7:0]  anA, anB;
  logic [6:0]  segA, segB;
  logic        dpA, dpB, fdA, fdB;

  int          errors = 0;
  int          checks = 0;
  int          p = 0;
  logic [31:0] bufV [2];
  logic [7:0]  bufDp[2];
  logic [7:0]  bufEn[2];

  always #5 clk = ~clk;

  sevenseg_scan #(.SCAN_DIV(S), .BLANK_CYCLES(BA)) dutA (
    .clk(clk), .reset(rstN), .value(value), .dp_mask(dpMask), .digit_en(digitEn),
    .an(anA), .seg(segA), .dp(dpA), .frame_done(fdA)
  );

  sevenseg_scan #(.SCAN_DIV(S), .BLANK_CYCLES(BB)) dutB (
    .clk(clk), .reset(rstN), .value(value), .dp_mask(dpMask), .digit_en(digitEn),
    .an(anB), .seg(segB), .dp(dpB), .frame_done(fdB)
  );

  // Lit segments of each hex glyph, by letter name.
  function automatic logic [6:0] glyphOf(input int n);
    string lit[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    logic [6:0] g;
    g = 7'h7F;
    for (int i = 0; i < lit[n].len(); i++) g[int'(lit[n][i]) - 97] = 1'b0;
    return g;
  endfunction

  // Where period p (counted from the last reset edge) falls in the scan.
  task automatic phaseOf(input int b, input int pp, output bit show, output int dig, output int cnt);
    int off, q;
    off  = (b == 0) ? 1 : 0;
    show = 1'b0;
    dig  = 0;
    cnt  = 0;
    if (pp >= off) begin
      q = (pp - off) % (8 * (S + b));
      if (q % (S + b) >= b) begin
        show = 1'b1;
        dig  = q / (S + b);
        cnt  = q % (S + b) - b;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s p=%0d observed=%h expected=%h", tag, p, obs, exp);
    end
  endtask

  task automatic checkOutput();
    bit         show;
    int         dig, cnt, hi;
    logic [7:0] eAn;
    logic [6:0] eSeg;
    logic       eDp, eFd;
    @(negedge clk);
    if (!rstN) begin
      p = 0;
      for (int k = 0; k < 2; k++) begin
        bufV[k] = '0; bufDp[k] = '0; bufEn[k] = '0;
      end
    end else begin
      p++;
    end
    for (int k = 0; k < 2; k++) begin
      phaseOf((k == 0) ? BA : BB, p, show, dig, cnt);
      if (show && dig == 0 && cnt == 0) begin
        bufV[k] = value; bufDp[k] = dpMask; bufEn[k] = digitEn;
      end
      hi = 0;
      for (int i = 0; i < 8; i++) if (((bufV[k] >> (4 * i)) & 32'hF) != 0) hi = i;
      eAn  = 8'hFF;
      eSeg = 7'h7F;
      eDp  = 1'b1;
      eFd  = show && dig == 7 && cnt == S - 1;
      if (show && bufEn[k][dig]) begin
        eDp = ~bufDp[k][dig];
        if (!(LZ && dig > hi)) begin
          eAn  = 8'hFF ^ (8'h01 << dig);
          eSeg = glyphOf(int'((bufV[k] >> (4 * dig)) & 32'hF));
        end
      end
      chk($sformatf("an%0d", k),  32'((k == 0) ? anA  : anB),  32'(eAn));
      chk($sformatf("seg%0d", k), 32'((k == 0) ? segA : segB), 32'(eSeg));
      chk($sformatf("dp%0d", k),  32'((k == 0) ? dpA  : dpB),  32'(eDp));
      chk($sformatf("fd%0d", k),  32'((k == 0) ? fdA  : fdB),  32'(eFd));
    end
  endtask

  task automatic applyStimulus(input logic [31:0] v, input logic [7:0] dpm, input logic [7:0] den,
                               input int n);
    value   = v;
    dpMask  = dpm;
    digitEn = den;
    for (int i = 0; i < n; i++) checkOutput();
  endtask

  initial begin
    int guard;
    rstN    = 1'b0;
    value   = '0;
    dpMask  = '0;
    digitEn = '0;
    for (int i = 0; i < 3; i++) checkOutput();
    rstN = 1'b1;
    applyStimulus(32'h76543210, 8'h00, 8'hFF, 60);
    applyStimulus(32'h00000099, 8'h00, 8'hFF, 100);
    applyStimulus(32'h00000042, 8'h04, 8'hFF, 100);
    applyStimulus(32'hFEDCBA98, 8'hA5, 8'hFF, 60);
    applyStimulus(32'hFEDCBA98, 8'h00, 8'h0F, 60);
    applyStimulus(32'h00000000, 8'h01, 8'hFF, 60);

    // Reset during digit 5 of the blanking scanner, then resume.
    applyStimulus(32'h13572468, 8'h10, 8'hFF, 1);
    guard = 0;
    while (p % (8 * (S + BA)) != 33 && guard < 100) begin
      checkOutput();
      guard++;
    end
    chk("reachDigit5", 32'(p % (8 * (S + BA))), 32'd33);
    rstN = 1'b0;
    checkOutput();
    rstN = 1'b1;
    applyStimulus(32'h89ABCDEF, 8'h00, 8'hFF, 60);

    for (int i = 0; i < 800; i++) begin
      value   = $urandom >> (4 * $urandom_range(0, 8));
      dpMask  = 8'($urandom);
      digitEn = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      rstN    = ($urandom_range(0, 199) != 0);
      checkOutput();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
